// File: rtl/gate_vec_pkg.sv
// Shared types and constants for the gate vector generator: FSM states,
// LFSR taps and seeds, corner-pattern count and the Galois step function.
package gate_vec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } vec_state_e;

  // Polynomial x^64 + x^63 + x^61 + x^60 + 1, right-shift Galois form.
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  // Seeds must be non-zero; an all-zero Galois LFSR never leaves zero.
  localparam logic [63:0] SEED1 = 64'h0000_0000_0000_0001;
  localparam logic [63:0] SEED2 = 64'h0000_0000_0000_ACE1;
  localparam logic [63:0] SEED3 = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam int N_CORNER = 4;

  // One Galois step: shift right, fold the taps in when bit 0 falls out.
  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 64'h0);
  endfunction

endpackage

// File: rtl/lfsr_galois64.sv
// 64-bit right-shift Galois LFSR. Resets to the SEED parameter, reloads
// from the seed input on load, and steps once per cycle on step.
// load has priority over step.
module lfsr_galois64
  import gate_vec_pkg::*;
#(
  parameter logic [63:0] SEED = SEED1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [63:0] seed,
  output logic [63:0] q
);

  // LFSR state register: reset to seed, reload, or advance one step.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the reset value is the seed, not zero, because zero is the
      // one state a Galois LFSR can never escape.
      q <= SEED;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/gate_vec_gen.sv
// Stimulus generator for the gate test top: presents in1/in2/in3 triples
// from three Galois LFSRs over valid/ready, num_vec vectors per start.
// Optional feature macro: GATE_VEC_CORNER_EN -- when defined, the first
// four vectors of each run are fixed corner patterns and the LFSRs hold
// during them, so vector 4 equals the seeds.
module gate_vec_gen #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] in3,
  output logic [CNT_W-1:0] vec_idx,
  output logic             busy,
  output logic             done
);

  import gate_vec_pkg::*;

`ifdef GATE_VEC_CORNER_EN
  localparam bit CORNER_EN = 1'b1;
`else
  localparam bit CORNER_EN = 1'b0;
`endif

  vec_state_e       state;
  logic [CNT_W-1:0] num_lat;
  logic [63:0]      q1, q2, q3;
  logic [63:0]      nxt1, nxt2, nxt3;
  logic [CNT_W-1:0] nxt_idx;
  logic [WIDTH-1:0] vin1, vin2, vin3;
  logic             load, accept, step, corner_now, corner_sel;

  // Run launch and vector acceptance; valid is always high in RUN.
  assign load       = (state == IDLE) && start && (num_vec != '0);
  assign accept     = (state == RUN) && ready;
  // LFSRs hold while a corner vector is the one being accepted.
  assign corner_now = CORNER_EN && (vec_idx < CNT_W'(N_CORNER));
  assign step       = accept && !corner_now;

  lfsr_galois64 #(.SEED(SEED1)) u_lfsr1 (
    .clk(clk), .rst_n(rst_n), .load(load), .step(step), .seed(SEED1), .q(q1)
  );
  lfsr_galois64 #(.SEED(SEED2)) u_lfsr2 (
    .clk(clk), .rst_n(rst_n), .load(load), .step(step), .seed(SEED2), .q(q2)
  );
  lfsr_galois64 #(.SEED(SEED3)) u_lfsr3 (
    .clk(clk), .rst_n(rst_n), .load(load), .step(step), .seed(SEED3), .q(q3)
  );

  // Value the output registers take on load/accept: the LFSR state after
  // this edge, or a corner pattern for indices below N_CORNER.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    nxt_idx    = load ? '0 : vec_idx + 1'b1;
    corner_sel = CORNER_EN && (nxt_idx < CNT_W'(N_CORNER));
    nxt1       = load ? SEED1 : (step ? lfsr_next(q1) : q1);
    nxt2       = load ? SEED2 : (step ? lfsr_next(q2) : q2);
    nxt3       = load ? SEED3 : (step ? lfsr_next(q3) : q3);
    vin1       = nxt1[WIDTH-1:0];
    vin2       = nxt2[WIDTH-1:0];
    vin3       = nxt3[WIDTH-1:0];
    if (corner_sel) begin
      // Index 0..3 -> (0,0,0), (0,1,1), (1,0,0), (1,1,1) replicated.
      vin1 = {WIDTH{nxt_idx[1]}};
      vin2 = {WIDTH{nxt_idx[0]}};
      vin3 = {WIDTH{nxt_idx[0]}};
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      num_lat <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      in1     <= '0;
      in2     <= '0;
      in3     <= '0;
      vec_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state   <= RUN;
            num_lat <= num_vec;
            valid   <= 1'b1;
            busy    <= 1'b1;
            vec_idx <= nxt_idx;
            in1     <= vin1;
            in2     <= vin2;
            in3     <= vin3;
          end else if (start) begin
            // Zero-length run: straight to DONE, nothing issued.
            state <= DONE;
            done  <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            vec_idx <= nxt_idx;
            in1     <= vin1;
            in2     <= vin2;
            in3     <= vin3;
            if (vec_idx == num_lat - 1'b1) begin
              state <= DONE;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vec_gen.sv
// Directed bench for gate_vec_gen. Default build checks reset, a basic
// 3-vector run, backpressure, zero-length runs and ignored start; with
// GATE_VEC_CORNER_EN defined it runs WIDTH=8 and checks corner patterns.
module tb_gate_vec_gen;

`ifdef GATE_VEC_CORNER_EN
  localparam int TB_W = 8;
`else
  localparam int TB_W = 64;
`endif
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [CW-1:0]   num_vec;
  logic            ready;
  logic            valid;
  logic [TB_W-1:0] in1, in2, in3;
  logic [CW-1:0]   vec_idx;
  logic            busy;
  logic            done;

  int total = 0;
  int bad   = 0;

  gate_vec_gen #(.WIDTH(TB_W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .ready(ready), .valid(valid), .in1(in1), .in2(in2), .in3(in3),
    .vec_idx(vec_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; num_vec = '0; ready = 1'b0;
    #2;
    total++;
    if ({valid, busy, done} !== 3'b000 || in1 !== '0 || in2 !== '0 ||
        in3 !== '0 || vec_idx !== '0) begin
      bad++;
      $display("FAIL reset_init got v=%b b=%b d=%b idx=%0d in1=%h want all 0",
               valid, busy, done, vec_idx, in1);
    end
    tick();
    rst_n = 1'b1;
    tick();
    // Start a run, accept two vectors, then reset mid-run.
    start = 1'b1; num_vec = 16'd5; ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    total++;
    if (vec_idx !== 16'd2 || valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_prerun got idx=%0d v=%b want idx=2 v=1", vec_idx, valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({valid, busy, done} !== 3'b000 || in1 !== '0 || in2 !== '0 ||
        in3 !== '0 || vec_idx !== '0) begin
      bad++;
      $display("FAIL reset_midrun got v=%b b=%b d=%b idx=%0d in1=%h want all 0",
               valid, busy, done, vec_idx, in1);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (done !== 1'b0 || valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold[%0d] got d=%b v=%b want 0 0", i, done, valid);
      end
    end
    rst_n = 1'b1;
    ready = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [63:0] e1 [3];
    logic [63:0] e2 [3];
    logic [63:0] e3 [3];
    int busy_cnt;
    e1[0] = 64'h0000_0000_0000_0001; e1[1] = 64'hD800_0000_0000_0000;
    e1[2] = 64'h6C00_0000_0000_0000;
    e2[0] = 64'h0000_0000_0000_ACE1; e2[1] = 64'hD800_0000_0000_5670;
    e2[2] = 64'h6C00_0000_0000_2B38;
    e3[0] = 64'hFFFF_FFFF_FFFF_FFFF; e3[1] = 64'hA7FF_FFFF_FFFF_FFFF;
    e3[2] = 64'h8BFF_FFFF_FFFF_FFFF;
    busy_cnt = 0;
    start = 1'b1; num_vec = 16'd3; ready = 1'b1;
    tick();
    start = 1'b0;
    num_vec = 16'd9;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (valid !== 1'b1 || vec_idx !== CW'(i) || done !== 1'b0) begin
        bad++;
        $display("FAIL basic_ctl[%0d] got v=%b idx=%0d d=%b want v=1 idx=%0d d=0",
                 i, valid, vec_idx, done, i);
      end
      total++;
      if (in1 !== TB_W'(e1[i]) || in2 !== TB_W'(e2[i]) || in3 !== TB_W'(e3[i])) begin
        bad++;
        $display("FAIL basic_vec[%0d] got %h %h %h want %h %h %h", i, in1, in2, in3,
                 TB_W'(e1[i]), TB_W'(e2[i]), TB_W'(e3[i]));
      end
      if (busy === 1'b1) busy_cnt++;
      tick();
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_done got d=%b b=%b v=%b want d=1 b=0 v=0", done, busy, valid);
    end
    tick();
    total++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_after got d=%b v=%b want 0 0", done, valid);
    end
    total++;
    if (busy_cnt != 3) begin
      bad++;
      $display("FAIL basic_busy_len got %0d want 3", busy_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    start = 1'b1; num_vec = 16'd3; ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (valid !== 1'b1 || vec_idx !== '0 || in1 !== TB_W'(64'h1) ||
          in2 !== TB_W'(64'hACE1) || in3 !== TB_W'(64'hFFFF_FFFF_FFFF_FFFF)) begin
        bad++;
        $display("FAIL bp_hold[%0d] got v=%b idx=%0d %h %h %h want v=1 idx=0 seeds",
                 i, valid, vec_idx, in1, in2, in3);
      end
      tick();
    end
    ready = 1'b1;
    tick();
    total++;
    if (vec_idx !== 16'd1 || in1 !== TB_W'(64'hD800_0000_0000_0000) ||
        in2 !== TB_W'(64'hD800_0000_0000_5670)) begin
      bad++;
      $display("FAIL bp_release got idx=%0d %h %h want idx=1 vector 1", vec_idx, in1, in2);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL bp_done_timeout got no done want done within 20 cycles");
    end
    ready = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    start = 1'b1; num_vec = '0; ready = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_done got d=%b v=%b b=%b want d=1 v=0 b=0", done, valid, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (done !== 1'b0 || valid !== 1'b0) begin
        bad++;
        $display("FAIL zero_after[%0d] got d=%b v=%b want 0 0", i, done, valid);
      end
    end
    ready = 1'b0;
  endtask

  task automatic test_ignored_start();
    start = 1'b1; num_vec = 16'd4; ready = 1'b1;
    tick();
    // Keep start high and change num_vec through RUN and DONE.
    num_vec = 16'd2;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (valid !== 1'b1 || vec_idx !== CW'(i)) begin
        bad++;
        $display("FAIL ign_run[%0d] got v=%b idx=%0d want v=1 idx=%0d", i, valid, vec_idx, i);
      end
      tick();
    end
    total++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      bad++;
      $display("FAIL ign_done got d=%b v=%b want d=1 v=0", done, valid);
    end
    tick();
    start = 1'b0;
    total++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL ign_no_restart got v=%b b=%b d=%b want 0 0 0", valid, busy, done);
    end
    tick();
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL ign_idle got v=%b want 0", valid);
    end
    ready = 1'b0;
  endtask

  task automatic test_corner();
    logic [7:0] c1 [6];
    logic [7:0] c2 [6];
    logic [7:0] c3 [6];
    c1 = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h00};
    c2 = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'hE1, 8'h70};
    c3 = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF};
    start = 1'b1; num_vec = 16'd6; ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (valid !== 1'b1 || vec_idx !== CW'(i) || in1 !== TB_W'(c1[i]) ||
          in2 !== TB_W'(c2[i]) || in3 !== TB_W'(c3[i])) begin
        bad++;
        $display("FAIL corner_vec[%0d] got v=%b idx=%0d %h %h %h want v=1 %h %h %h",
                 i, valid, vec_idx, in1, in2, in3, c1[i], c2[i], c3[i]);
      end
      tick();
    end
    total++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      bad++;
      $display("FAIL corner_done got d=%b v=%b want d=1 v=0", done, valid);
    end
    tick();
    ready = 1'b0;
  endtask

  initial begin
    test_reset();
`ifdef GATE_VEC_CORNER_EN
    test_corner();
    test_zero();
    test_ignored_start();
`else
    test_basic();
    test_backpressure();
    test_zero();
    test_ignored_start();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
